// File: rtl/alu_req_queue.sv
// Request FIFO in front of an external combinational 8-bit ALU, with a registered,
// back-pressurable result stage. Optional macro ALU_REQ_ILLEGAL_CHECK_EN enables out_err.
module alu_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_a,
    input  logic [7:0]                 in_b,
    input  logic [2:0]                 in_op,
    output logic [7:0]                 alu_a,
    output logic [7:0]                 alu_b,
    output logic [2:0]                 alu_op,
    input  logic [7:0]                 alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_result,
    output logic [2:0]                 out_op,
    output logic                       out_err,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

    logic [18:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] count_s;
    logic [18:0]   head_s;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;

    logic          out_valid_r;
    logic [7:0]    out_result_r;
    logic [2:0]    out_op_r;

    // Occupancy, handshake qualifiers and head entry decode.
    always_comb begin
        count_s = wr_ptr_r - rd_ptr_r;
        empty_s = (count_s == PTR_ZERO);
        full_s  = (count_s == FULL_CNT);
        head_s  = mem_r[rd_ptr_r[AW-1:0]];
        push_s  = in_valid && !full_s;
        // Refuse pushes when full even if a pop frees a slot this cycle: keeps out_ready off in_ready.
        pop_s   = !empty_s && (!out_valid_r || out_ready);
    end

    // Head of the FIFO feeds the ALU; idle pattern when empty.
    always_comb begin
        if (!empty_s) begin
            alu_op = head_s[18:16];
            alu_a  = head_s[15:8];
            alu_b  = head_s[7:0];
        end else begin
            alu_op = 3'b111;
            alu_a  = 8'd0;
            alu_b  = 8'd0;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 19'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {in_op, in_a, in_b};
        end
    end

    // Read/write pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Output stage: capture the ALU result on pop, drop valid when consumed without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_result_r <= 8'd0;
            out_op_r     <= 3'd0;
        end else if (pop_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= alu_result;
            out_op_r     <= head_s[18:16];
        end else if (out_valid_r && out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

`ifdef ALU_REQ_ILLEGAL_CHECK_EN
    logic out_err_r;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op > 3'b100);
    endfunction

    // Illegal-opcode flag travels with the captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err_r <= 1'b0;
        end else if (pop_s) begin
            out_err_r <= op_is_illegal(head_s[18:16]);
        end
    end

    assign out_err = out_err_r;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready   = !full_s;
    assign count      = count_s;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_op     = out_op_r;

endmodule

// File: tb/tb_alu_req_queue.sv
// Bench for alu_req_queue: directed test-plan steps plus random traffic against a queue-based model.
module tb_alu_req_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_op;
    logic       out_err;
    logic [2:0] count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [18:0] mq[$];
    logic        mv   = 1'b0;
    logic [7:0]  mres = 8'd0;
    logic [2:0]  mop  = 3'd0;
    logic        merr = 1'b0;

    alu_req_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op), .out_err(out_err),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 8'd0;
        endcase
    endfunction

    // External ALU
    always_comb alu_result = alu_f(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [18:0] h;
        h = (mq.size() != 0) ? mq[0] : {3'b111, 8'd0, 8'd0};
        chk("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
        chk("count",      32'(count),      32'(mq.size()));
        chk("alu_op",     32'(alu_op),     32'(h[18:16]));
        chk("alu_a",      32'(alu_a),      32'(h[15:8]));
        chk("alu_b",      32'(alu_b),      32'(h[7:0]));
        chk("out_valid",  32'(out_valid),  32'(mv));
        chk("out_result", 32'(out_result), 32'(mres));
        chk("out_op",     32'(out_op),     32'(mop));
        chk("out_err",    32'(out_err),    32'(merr));
    endtask

    task automatic model_step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input logic ordy);
        logic        rdy;
        logic [18:0] h;
        rdy = (mq.size() != DEPTH);
        if (mq.size() != 0 && (!mv || ordy)) begin
            h    = mq.pop_front();
            mv   = 1'b1;
            mres = alu_f(h[15:8], h[7:0], h[18:16]);
            mop  = h[18:16];
`ifdef ALU_REQ_ILLEGAL_CHECK_EN
            merr = (h[18:16] > 3'd4);
`else
            merr = 1'b0;
`endif
        end else if (mv && ordy) begin
            mv = 1'b0;
        end
        if (iv && rdy) mq.push_back({op, a, b});
    endtask

    task automatic model_reset();
        mq.delete();
        mv = 1'b0; mres = 8'd0; mop = 3'd0; merr = 1'b0;
    endtask

    // One clock: check current outputs, drive inputs, advance model on the edge.
    task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic ordy);
        check_all();
        in_valid = iv; in_a = a; in_b = b; in_op = op; out_ready = ordy;
        @(posedge clk);
        model_step(iv, a, b, op, ordy);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_op = 3'd0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_op",   32'(alu_op),   32'd7);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back ops, latency 2 edges
        cycle(1'b1, 8'd10, 8'd3, 3'd0, 1'b1);
        chk("lat_valid0", 32'(out_valid), 32'd0);
        cycle(1'b1, 8'd10, 8'd3, 3'd1, 1'b1);
        chk("lat_valid1", 32'(out_valid), 32'd1);
        chk("add", 32'(out_result), 32'd13);
        cycle(1'b1, 8'd10, 8'd3, 3'd2, 1'b1);
        chk("sub", 32'(out_result), 32'd7);
        cycle(1'b1, 8'd10, 8'd3, 3'd3, 1'b1);
        chk("and", 32'(out_result), 32'd2);
        cycle(1'b1, 8'd10, 8'd3, 3'd4, 1'b1);
        chk("or", 32'(out_result), 32'd11);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        chk("xor", 32'(out_result), 32'd9);
        chk("xor_op", 32'(out_op), 32'd4);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Modulo wrap
        cycle(1'b1, 8'd3, 8'd10, 3'd1, 1'b1);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        chk("wrap_sub", 32'(out_result), 32'd249);
        cycle(1'b1, 8'd200, 8'd100, 3'd0, 1'b1);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        chk("wrap_add", 32'(out_result), 32'd44);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);

        // Backpressure: DEPTH+1 accepts
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (in_ready) acc++;
            cycle(1'b1, 8'(21 + i), 8'd0, 3'd0, 1'b0);
        end
        chk("bp_accepts", 32'(acc), 32'd5);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_first", 32'(out_result), 32'd21);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_r22", 32'(out_result), 32'd22);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
            chk("bp_order", 32'(out_result), 32'(23 + i));
        end
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        chk("bp_done", 32'(out_valid), 32'd0);

        // Full plus simultaneous pop
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i), 8'd7, 3'd4, 1'b0);
        chk("fp_full", 32'(in_ready), 32'd0);
        cycle(1'b1, 8'd99, 8'd1, 3'd0, 1'b1);
        chk("fp_nopush_cnt", 32'(count), 32'd3);
        cycle(1'b1, 8'd98, 8'd1, 3'd0, 1'b1);
        chk("fp_both_cnt", 32'(count), 32'd3);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);

`ifdef ALU_REQ_ILLEGAL_CHECK_EN
        cycle(1'b1, 8'd5, 8'd5, 3'd7, 1'b1);
        cycle(1'b1, 8'd1, 8'd2, 3'd0, 1'b1);
        chk("ill_res", 32'(out_result), 32'd0);
        chk("ill_op",  32'(out_op),     32'd7);
        chk("ill_err", 32'(out_err),    32'd1);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        chk("legal_res", 32'(out_result), 32'd3);
        chk("legal_err", 32'(out_err),    32'd0);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
`endif

        // Reset mid-stream
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(40 + i), 8'd2, 3'd1, 1'b0);
        chk("mid_count", 32'(count), 32'd3);
        chk("mid_valid", 32'(out_valid), 32'd1);
        #2;
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_valid",    32'(out_valid), 32'd0);
        chk("ar_count",    32'(count),     32'd0);
        chk("ar_in_ready", 32'(in_ready),  32'd1);
        chk("ar_alu_op",   32'(alu_op),    32'd7);
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        model_step(1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
        end
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
